// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep generator and response checker for an N_IN-input, single-output combinational gate.
// Each vector is held HOLD cycles, then dut_out is compared against the latched reference function.
module gate_sweep_checker #(
    parameter int N_IN = 4,
    parameter int HOLD = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [1:0]      op_sel,
    input  logic            dut_out,
    output logic [N_IN-1:0] dut_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_err_vec,
    output logic            first_err_valid
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] dut_in_q, dut_in_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [1:0]      op_q, op_d;
    logic [N_IN:0]   err_cnt_q, err_cnt_d;
    logic [N_IN-1:0] first_err_vec_q, first_err_vec_d;
    logic            first_err_valid_q, first_err_valid_d;
    logic            done_q, done_d;
    logic            pass_q, pass_d;

    logic            expected;
    logic            mismatch;
    logic [N_IN:0]   err_inc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q           <= S_IDLE;
            dut_in_q          <= '0;
            hold_q            <= '0;
            op_q              <= '0;
            err_cnt_q         <= '0;
            first_err_vec_q   <= '0;
            first_err_valid_q <= 1'b0;
            done_q            <= 1'b0;
            pass_q            <= 1'b0;
        end else begin
            state_q           <= state_d;
            dut_in_q          <= dut_in_d;
            hold_q            <= hold_d;
            op_q              <= op_d;
            err_cnt_q         <= err_cnt_d;
            first_err_vec_q   <= first_err_vec_d;
            first_err_valid_q <= first_err_valid_d;
            done_q            <= done_d;
            pass_q            <= pass_d;
        end
    end

    always_comb begin
        expected = 1'b0;
        case (op_q)
            2'd0:    expected = ~&dut_in_q;
            2'd1:    expected = &dut_in_q;
            2'd2:    expected = ~|dut_in_q;
            default: expected = ^dut_in_q;
        endcase
        mismatch = (dut_out != expected);
        err_inc  = err_cnt_q + {{N_IN{1'b0}}, mismatch};
    end

    always_comb begin
        state_d           = state_q;
        dut_in_d          = dut_in_q;
        hold_d            = hold_q;
        op_d              = op_q;
        err_cnt_d         = err_cnt_q;
        first_err_vec_d   = first_err_vec_q;
        first_err_valid_d = first_err_valid_q;
        done_d            = done_q;
        pass_d            = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d           = S_RUN;
                    op_d              = op_sel;
                    err_cnt_d         = '0;
                    first_err_vec_d   = '0;
                    first_err_valid_d = 1'b0;
                    done_d            = 1'b0;
                    pass_d            = 1'b0;
                    dut_in_d          = '0;
                    hold_d            = '0;
                end
            end
            S_RUN: begin
                if (hold_q == HOLD_LAST) begin
                    err_cnt_d = err_inc;
                    if (mismatch && !first_err_valid_q) begin
                        first_err_vec_d   = dut_in_q;
                        first_err_valid_d = 1'b1;
                    end
                    hold_d = '0;
                    // All-ones is the last vector, so the vector counter never wraps in RUN.
                    if (dut_in_q != '1) begin
                        dut_in_d = dut_in_q + 1'b1;
                    end else begin
                        state_d  = S_DONE;
                        done_d   = 1'b1;
                        dut_in_d = '0;
                        pass_d   = (err_inc == '0);
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        dut_in          = dut_in_q;
        busy            = (state_q == S_RUN);
        done            = done_q;
        pass            = pass_q;
        err_cnt         = err_cnt_q;
        first_err_vec   = first_err_vec_q;
        first_err_valid = first_err_valid_q;
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (N_IN=4/HOLD=2, N_IN=1/HOLD=1, N_IN=1/HOLD=3)
// with expected sweep results queued at start and compared when done is observed.
module tb_gate_sweep_checker;

    typedef struct {
        int err;
        int fvec;
        bit fvalid;
        bit pass;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_v = 1'b0;
    logic [1:0] op_v = 2'd0;
    int sel = 0;
    int fn_v = 0;

    int n_checks = 0;
    int n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    logic        start4, start1a, start1b;
    logic        dout4, dout1a, dout1b;
    logic [3:0]  din4;
    logic [0:0]  din1a, din1b;
    logic        busy4, busy1a, busy1b, done4, done1a, done1b, pass4, pass1a, pass1b;
    logic [4:0]  err4;
    logic [1:0]  err1a, err1b;
    logic [3:0]  fev4;
    logic [0:0]  fev1a, fev1b;
    logic        fv4, fv1a, fv1b;

    assign start4  = start_v && (sel == 0);
    assign start1a = start_v && (sel == 1);
    assign start1b = start_v && (sel == 2);

    // Popcount-based reference, deliberately written differently from reduction operators.
    function automatic bit ref_fn(input int v, input int n, input int op);
        int cnt = 0;
        for (int i = 0; i < n; i++) cnt += (v >> i) & 1;
        case (op)
            0: return cnt != n;
            1: return cnt == n;
            2: return cnt == 0;
            default: return (cnt % 2) == 1;
        endcase
    endfunction

    function automatic bit dut_model(input int v, input int n, input int fn);
        if (fn == 4) return 1'b1;
        return ref_fn(v, n, fn);
    endfunction

    function automatic exp_t model(input int n, input int op, input int fn);
        exp_t e;
        e.err = 0; e.fvec = 0; e.fvalid = 0;
        for (int v = 0; v < (1 << n); v++) begin
            if (dut_model(v, n, fn) != ref_fn(v, n, op)) begin
                if (!e.fvalid) begin e.fvec = v; e.fvalid = 1; end
                e.err++;
            end
        end
        e.pass = (e.err == 0);
        return e;
    endfunction

    always_comb begin
        dout4  = dut_model(int'(din4), 4, fn_v);
        dout1a = dut_model(int'(din1a), 1, fn_v);
        dout1b = dut_model(int'(din1b), 1, fn_v);
    end

    gate_sweep_checker #(.N_IN(4), .HOLD(2)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .op_sel(op_v), .dut_out(dout4),
        .dut_in(din4), .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4),
        .first_err_vec(fev4), .first_err_valid(fv4));

    gate_sweep_checker #(.N_IN(1), .HOLD(1)) u_dut1a (
        .clk(clk), .rst_n(rst_n), .start(start1a), .op_sel(op_v), .dut_out(dout1a),
        .dut_in(din1a), .busy(busy1a), .done(done1a), .pass(pass1a), .err_cnt(err1a),
        .first_err_vec(fev1a), .first_err_valid(fv1a));

    gate_sweep_checker #(.N_IN(1), .HOLD(3)) u_dut1b (
        .clk(clk), .rst_n(rst_n), .start(start1b), .op_sel(op_v), .dut_out(dout1b),
        .dut_in(din1b), .busy(busy1b), .done(done1b), .pass(pass1b), .err_cnt(err1b),
        .first_err_vec(fev1b), .first_err_valid(fv1b));

    int  o_din, o_err, o_fev;
    bit  o_busy, o_done, o_pass, o_fv;

    always_comb begin
        case (sel)
            1: begin o_din = int'(din1a); o_err = int'(err1a); o_fev = int'(fev1a);
                     o_busy = busy1a; o_done = done1a; o_pass = pass1a; o_fv = fv1a; end
            2: begin o_din = int'(din1b); o_err = int'(err1b); o_fev = int'(fev1b);
                     o_busy = busy1b; o_done = done1b; o_pass = pass1b; o_fv = fv1b; end
            default: begin o_din = int'(din4); o_err = int'(err4); o_fev = int'(fev4);
                     o_busy = busy4; o_done = done4; o_pass = pass4; o_fv = fv4; end
        endcase
    end

    task automatic check_idle_zero(input string name);
        n_checks++;
        if (o_din !== 0 || o_busy !== 1'b0 || o_done !== 1'b0 || o_pass !== 1'b0 ||
            o_err !== 0 || o_fev !== 0 || o_fv !== 1'b0) begin
            n_fail++;
            $display("FAIL %s sel=%0d: din=%0d busy=%0b done=%0b pass=%0b err=%0d fev=%0d fv=%0b, required all zero",
                     name, sel, o_din, o_busy, o_done, o_pass, o_err, o_fev, o_fv);
        end
    endtask

    // Full sweep on instance sel_i; checks vector stepping every cycle and exact done latency.
    task automatic sweep(input int sel_i, input int n, input int hold, input logic [1:0] op,
                         input int fn, input bit toggle, input bit keep);
        exp_t e;
        int total;
        sel = sel_i;
        fn_v = fn;
        total = (1 << n) * hold;
        sb.push_back(model(n, int'(op), fn));
        @(negedge clk);
        op_v = op;
        start_v = 1'b1;
        @(posedge clk);
        #1;
        if (!keep) start_v = 1'b0;
        for (int k = 0; k < total; k++) begin
            @(negedge clk);
            n_checks++;
            if (o_busy !== 1'b1 || o_done !== 1'b0 || o_din !== k / hold) begin
                n_fail++;
                $display("FAIL run_step sel=%0d k=%0d: busy=%0b done=%0b din=%0d, required busy=1 done=0 din=%0d",
                         sel, k, o_busy, o_done, o_din, k / hold);
            end
            if (toggle && k == 3) op_v = ~op_v;
        end
        @(negedge clk);
        e = sb.pop_front();
        n_checks++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_din !== 0) begin
            n_fail++;
            $display("FAIL done_latency sel=%0d: done=%0b busy=%0b din=%0d after %0d cycles, required done=1 busy=0 din=0",
                     sel, o_done, o_busy, o_din, total);
        end
        n_checks++;
        if (o_err !== e.err || o_fev !== e.fvec || o_fv !== e.fvalid || o_pass !== e.pass) begin
            n_fail++;
            $display("FAIL result sel=%0d op=%0d: err=%0d fev=%0d fv=%0b pass=%0b, required err=%0d fev=%0d fv=%0b pass=%0b",
                     sel, op, o_err, o_fev, o_fv, o_pass, e.err, e.fvec, e.fvalid, e.pass);
        end
        $display("sweep sel=%0d n=%0d hold=%0d op=%0d dut_fn=%0d -> err=%0d fev=%0d fv=%0b pass=%0b",
                 sel, n, hold, op, fn, o_err, o_fev, o_fv, o_pass);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        start_v = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            check_idle_zero("reset_state");
        end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_nand_pass();
        sweep(0, 4, 2, 2'd0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_stuck_one();
        sweep(0, 4, 2, 2'd0, 4, 1'b0, 1'b0);
    endtask

    task automatic test_xor_vs_nand();
        sweep(0, 4, 2, 2'd3, 0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        bit seen = 0;
        sel = 0;
        fn_v = 0;
        @(negedge clk);
        op_v = 2'd0;
        start_v = 1'b1;
        @(negedge clk);
        start_v = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (o_din == 6) seen = 1;
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL reach_vec6: din=%0d, required 6 within 40 cycles", o_din);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        $display("async reset mid-sweep applied");
        sweep(0, 4, 2, 2'd0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        sweep(0, 4, 2, 2'd0, 4, 1'b0, 1'b1);
        fn_v = 0;
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b1 || o_done !== 1'b0 || o_pass !== 1'b0 || o_err !== 0 ||
            o_fv !== 1'b0 || o_din !== 0) begin
            n_fail++;
            $display("FAIL restart: busy=%0b done=%0b pass=%0b err=%0d fv=%0b din=%0d, required busy=1 done=0 pass=0 err=0 fv=0 din=0",
                     o_busy, o_done, o_pass, o_err, o_fv, o_din);
        end
        $display("restart from DONE observed busy=%0b err=%0d", o_busy, o_err);
        pulse_reset();
    endtask

    task automatic test_small_gate();
        sweep(1, 1, 1, 2'd2, 2, 1'b0, 1'b0);
        sweep(2, 1, 3, 2'd2, 2, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_nand_pass();
        test_stuck_one();
        test_xor_vs_nand();
        test_async_reset();
        test_back_to_back();
        test_small_gate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
Name: gate_sweep_checker

Overview:
Self-contained exhaustive stimulus generator and response checker for N-input single-output combinational gates. It is the parametrised successor of the hand-timed 4-input NAND toggle bench. It drives every input vector 0..2^N_IN-1 in binary order, holds each vector for a programmable number of cycles, and compares the DUT output against a selectable reference function. It reports mismatch count, first failing vector, and pass/fail. It sits beside any gate-level DUT in a bench or on-board self-test wrapper.

Parameters:
N_IN, 4, number of DUT inputs (1..16)
HOLD, 1, clock cycles each vector is held before the DUT output is sampled (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  begin sweep; sampled only in IDLE or DONE
op_sel  input  2  reference function: 0 NAND, 1 AND, 2 NOR, 3 XOR (odd parity)
dut_out  input  1  DUT response
dut_in  output  N_IN  vector driven to DUT
busy  output  1  high while sweep running
done  output  1  sticky sweep-complete flag
pass  output  1  done and err_cnt==0
err_cnt  output  N_IN+1  number of mismatching vectors
first_err_vec  output  N_IN  first mismatching vector
first_err_valid  output  1  first_err_vec holds a valid value

Behaviour:
- Reset (async, rst_n low): state IDLE; dut_in=0, busy=0, done=0, pass=0, err_cnt=0, first_err_vec=0, first_err_valid=0, hold counter=0, latched op=0. Takes effect immediately, including mid-sweep. No partial results are retained.
- States: IDLE, RUN, DONE.
- IDLE/DONE + start=1 at edge E0 -> RUN:
  - latch op_sel
  - clear err_cnt, first_err_vec, first_err_valid, done, pass
  - dut_in=0, hold=0, busy=1
- IDLE/DONE + start=0: hold all outputs.
- RUN:
  - start and op_sel changes are ignored.
  - hold counts 0..HOLD-1; dut_in is stable over those HOLD cycles.
  - At the edge where hold==HOLD-1, sample dut_out and compare with expected(dut_in, latched op).
  - On mismatch: err_cnt+1. If first_err_valid==0, capture dut_in into first_err_vec and set first_err_valid=1.
  - If dut_in != all-ones at that edge: dut_in+1, hold=0.
  - If dut_in == all-ones at that edge: record the final compare result, then state DONE, busy=0, done=1, dut_in=0, pass=(final err_cnt==0).
- Latency: done rises exactly 2^N_IN*HOLD cycles after E0.
- Arithmetic:
  - err_cnt is N_IN+1 bits and reaches at most 2^N_IN, so it never wraps.
  - dut_in all-ones detection terminates the sweep; dut_in never wraps to 0 while in RUN.
- Expected values: NAND = ~&v, AND = &v, NOR = ~|v, XOR = ^v.
- HOLD=1: one compare per cycle; the hold counter is degenerate (always 0).
- Start asserted on the same edge DONE is entered is ignored (state was RUN). Start on the next edge restarts the sweep.
- DONE: outputs held until the next start or reset.

Test Plan:
1. N_IN=4, HOLD=2, op=NAND, correct NAND model, start pulse at E0 -> dut_in steps 0..F every 2 cycles; done=1 and busy=0 after 32 cycles; err_cnt=0, pass=1, first_err_valid=0.
2. Same config, dut_out stuck at 1 -> err_cnt=1, first_err_vec=4'hF, first_err_valid=1, pass=0.
3. op=XOR, NAND model as DUT -> err_cnt=7 (even-weight vectors except F), first_err_vec=4'h0, pass=0. Toggle op_sel mid-run -> result unchanged.
4. Reset low asynchronously mid-sweep at dut_in=6 -> all outputs 0 immediately, no clock edge required. Release and start again -> clean full sweep, pass=1.
5. Start held high throughout RUN -> no restart; done at 32 cycles. Start kept high into DONE -> new sweep begins the edge after DONE, with err_cnt, first_err_valid, done and pass cleared.
6. HOLD=1, N_IN=1, op=NOR, correct model -> dut_in 0,1; done after 2 cycles; pass=1. Repeat with HOLD=3 -> done after 6 cycles.
